// File: rtl/janela_controle_if.sv
// janela_controle_if -- handshake and strobe bundle between the measurement
// sequencer and its neighbours.
//   master : control/user side (drives iniciar, janela, estouro, continuo)
//   slave  : the sequencer itself (drives the counter strobes and status)
// The continuo signal exists only when JANELA_CONT_EN is defined.
interface janela_controle_if #(
  parameter int JAN_W = 16
);
  logic             iniciar;
  logic [JAN_W-1:0] janela;
  logic             estouro;
`ifdef JANELA_CONT_EN
  logic             continuo;
`endif
  logic             limp;
  logic             hab;
  logic             arm;
  logic             ocupado;
  logic             pronto;
  logic             erro;

`ifdef JANELA_CONT_EN
  modport master (
    output iniciar, janela, estouro, continuo,
    input  limp, hab, arm, ocupado, pronto, erro
  );

  modport slave (
    input  iniciar, janela, estouro, continuo,
    output limp, hab, arm, ocupado, pronto, erro
  );
`else
  modport master (
    output iniciar, janela, estouro,
    input  limp, hab, arm, ocupado, pronto, erro
  );

  modport slave (
    input  iniciar, janela, estouro,
    output limp, hab, arm, ocupado, pronto, erro
  );
`endif
endinterface

// File: rtl/janela_controle.sv
// janela_controle -- measurement sequencer for the frequency-meter datapath.
// One accepted start produces: limp (clear), two guard cycles around a count
// window of N cycles on hab, then arm (store), then a one-cycle pronto.
// An overflow seen during the window aborts straight to the completion pulse,
// skipping arm so the output register keeps its previous value, and sets a
// sticky erro that only the next accepted start clears.
// Optional build macro: JANELA_CONT_EN -- adds bus.continuo; when high in FIM
// the sequencer restarts immediately (re-latching janela) instead of idling.
module janela_controle #(
  parameter int JAN_W = 16
) (
  input  logic                clk_controle,
  input  logic                reset,
  janela_controle_if.slave    bus
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    LIMPA    = 3'd1,
    GUARDA1  = 3'd2,
    CONTA    = 3'd3,
    GUARDA2  = 3'd4,
    ARMAZENA = 3'd5,
    FIM      = 3'd6
  } estado_t;

  localparam logic [JAN_W-1:0] UM = JAN_W'(1);

  estado_t          estado_q, estado_d;
  logic [JAN_W-1:0] cont_q, cont_d;
  logic             erro_q, erro_d;

  logic             limp_q, limp_d;
  logic             hab_q, hab_d;
  logic             arm_q, arm_d;
  logic             ocupado_q, ocupado_d;
  logic             pronto_q, pronto_d;

  // A zero-length request still yields a one-cycle window.
  logic [JAN_W-1:0] janela_ef;
  logic             carrega;
  logic             reinicia;

  assign janela_ef = (bus.janela == '0) ? UM : bus.janela;

`ifdef JANELA_CONT_EN
  assign reinicia = bus.continuo;
`else
  assign reinicia = 1'b0;
`endif

  // Next-state, window down-counter and sticky error logic.
  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    erro_d   = erro_q;
    carrega  = 1'b0;

    unique case (estado_q)
      OCIOSO: begin
        if (bus.iniciar) begin
          estado_d = LIMPA;
          carrega  = 1'b1;
        end
      end
      LIMPA:   estado_d = GUARDA1;
      GUARDA1: estado_d = CONTA;
      CONTA: begin
        // Overflow wins over normal window expiry: abort without storing.
        if (bus.estouro) begin
          estado_d = FIM;
          erro_d   = 1'b1;
        end else begin
          cont_d = cont_q - UM;
          if (cont_q == UM) begin
            estado_d = GUARDA2;
          end
        end
      end
      GUARDA2:  estado_d = ARMAZENA;
      ARMAZENA: estado_d = FIM;
      FIM: begin
        if (reinicia) begin
          estado_d = LIMPA;
          carrega  = 1'b1;
        end else begin
          estado_d = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // Every accepted start (including a continuous restart) latches the
    // window length and clears the previous overflow indication.
    if (carrega) begin
      cont_d = janela_ef;
      erro_d = 1'b0;
    end
  end

  // Moore decode of the next state so every output leaves a flop.
  always_comb begin
    limp_d    = 1'b0;
    hab_d     = 1'b0;
    arm_d     = 1'b0;
    pronto_d  = 1'b0;
    ocupado_d = (estado_d != OCIOSO);

    unique case (estado_d)
      LIMPA:    limp_d   = 1'b1;
      CONTA:    hab_d    = 1'b1;
      ARMAZENA: arm_d    = 1'b1;
      FIM:      pronto_d = 1'b1;
      default:  ;
    endcase
  end

  // State register and window counter.
  always_ff @(posedge clk_controle or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
    end
  end

  // Registered outputs, including the sticky error flag.
  always_ff @(posedge clk_controle or negedge reset) begin
    if (!reset) begin
      limp_q    <= 1'b0;
      hab_q     <= 1'b0;
      arm_q     <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      limp_q    <= limp_d;
      hab_q     <= hab_d;
      arm_q     <= arm_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
    end
  end

  assign bus.limp    = limp_q;
  assign bus.hab     = hab_q;
  assign bus.arm     = arm_q;
  assign bus.ocupado = ocupado_q;
  assign bus.pronto  = pronto_q;
  assign bus.erro    = erro_q;

endmodule

// File: tb/tb_janela_controle.sv
// tb_janela_controle -- directed bench for janela_controle with a scoreboard.
// Stimulus pushes the expected timeline of each sequence; a monitor collects
// the strobes observed and compares them when pronto appears.
`timescale 1ns/1ps
module tb_janela_controle;

  localparam int JAN_W = 16;

  typedef struct {
    int t_limp;
    int t_hab0;
    int n_hab;
    int t_arm;      // -1 when arm must not appear
    int t_pronto;
    bit erro;
    bit ocup_next;  // ocupado expected in the cycle after pronto
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   nchk;
  int   nerr;
  exp_t sb[$];

  janela_controle_if #(.JAN_W(JAN_W)) bus ();

  janela_controle #(.JAN_W(JAN_W)) dut (
    .clk_controle (clk),
    .reset        (reset),
    .bus          (bus)
  );

  logic [5:0] outs;
  assign outs = {bus.limp, bus.hab, bus.arm, bus.ocupado, bus.pronto, bus.erro};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    nchk++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic void push(input int t, input int n, input int ovf_k, input bit ocup_next);
    exp_t e;
    int nn;
    nn = (n == 0) ? 1 : n;
    e.t_limp    = t;
    e.t_hab0    = t + 2;
    e.ocup_next = ocup_next;
    if (ovf_k > 0) begin
      e.n_hab    = ovf_k;
      e.t_arm    = -1;
      e.t_pronto = t + 2 + ovf_k;
      e.erro     = 1'b1;
    end else begin
      e.n_hab    = nn;
      e.t_arm    = t + nn + 3;
      e.t_pronto = t + nn + 4;
      e.erro     = 1'b0;
    end
    sb.push_back(e);
  endfunction

  task automatic start(input int n, output int t);
    bus.janela  = JAN_W'(n);
    bus.iniciar = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    bus.iniciar = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 100000 && cyc < c; i++) @(negedge clk);
    chk("wait_cycle_reached", cyc, c);
  endtask

  task automatic wait_idle(input int limit);
    int i;
    i = 0;
    while (bus.ocupado && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk("sequence_terminates", bus.ocupado, 0);
    @(negedge clk);
  endtask

  // Monitor: accumulate strobe activity per sequence, compare on pronto.
  initial begin
    int  limp_n, t_limp, hab_n, t_hab0, t_hab1, arm_n, t_arm;
    bit  pend_ocup, pend_val;
    exp_t e;
    limp_n = 0; t_limp = 0; hab_n = 0; t_hab0 = 0; t_hab1 = 0; arm_n = 0; t_arm = 0;
    pend_ocup = 0; pend_val = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        limp_n = 0; hab_n = 0; arm_n = 0; pend_ocup = 0;
      end else begin
        chk("strobes_exclusive", (int'(bus.limp) + int'(bus.hab) + int'(bus.arm)) <= 1, 1);
        if (pend_ocup) begin
          chk("ocupado_after_pronto", bus.ocupado, pend_val);
          pend_ocup = 0;
        end
        if (bus.limp) begin
          if (limp_n == 0) t_limp = cyc;
          limp_n++;
        end
        if (bus.hab) begin
          if (hab_n == 0) t_hab0 = cyc;
          hab_n++;
          t_hab1 = cyc;
        end
        if (bus.arm) begin
          if (arm_n == 0) t_arm = cyc;
          arm_n++;
        end
        if (bus.pronto) begin
          chk("pronto_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("limp_count", limp_n, 1);
            chk("limp_time", t_limp, e.t_limp);
            chk("hab_count", hab_n, e.n_hab);
            chk("hab_first", t_hab0, e.t_hab0);
            chk("hab_last", t_hab1, e.t_hab0 + e.n_hab - 1);
            chk("arm_count", arm_n, (e.t_arm >= 0) ? 1 : 0);
            if (e.t_arm >= 0) chk("arm_time", t_arm, e.t_arm);
            chk("pronto_time", cyc, e.t_pronto);
            chk("erro_at_pronto", bus.erro, e.erro);
            chk("ocupado_at_pronto", bus.ocupado, 1);
            pend_ocup = 1;
            pend_val  = e.ocup_next;
          end
          limp_n = 0; hab_n = 0; arm_n = 0;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int t, t1;
    nchk = 0;
    nerr = 0;
    reset       = 1'b0;
    bus.iniciar = 1'b0;
    bus.janela  = '0;
    bus.estouro = 1'b0;
`ifdef JANELA_CONT_EN
    bus.continuo = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, 0);
    reset = 1'b1;

    // Idle after reset release.
    repeat (20) begin
      @(negedge clk);
      chk("idle_outputs", outs, 0);
    end

    // Basic window of 5, with estouro pulses outside CONTA (ignored).
    start(5, t);
    push(t, 5, 0, 1'b0);
    bus.estouro = 1'b1;
    @(negedge clk);
    bus.estouro = 1'b0;
    wait_cyc(t + 5 + 2);
    bus.estouro = 1'b1;
    @(negedge clk);
    bus.estouro = 1'b0;
    wait_idle(100);
    chk("erro_after_normal", bus.erro, 0);

    // Zero-length request gives a one-cycle window.
    start(0, t);
    push(t, 0, 0, 1'b0);
    wait_idle(100);

    // Second iniciar during hab and janela change are both ignored.
    start(3, t);
    push(t, 3, 0, 1'b0);
    bus.janela = JAN_W'(9);
    wait_cyc(t + 3);
    bus.iniciar = 1'b1;
    @(negedge clk);
    bus.iniciar = 1'b0;
    wait_idle(100);

    // iniciar held: the next sequence starts right after returning to idle.
    bus.janela  = JAN_W'(1);
    bus.iniciar = 1'b1;
    t1 = cyc + 1;
    push(t1, 1, 0, 1'b0);
    push(t1 + 7, 1, 0, 1'b0);
    wait_cyc(t1 + 7);
    bus.iniciar = 1'b0;
    wait_idle(100);

    // Overflow on the 4th hab cycle: abort, no arm, sticky erro.
    start(10, t);
    push(t, 10, 4, 1'b0);
    wait_cyc(t + 5);
    bus.estouro = 1'b1;
    @(negedge clk);
    bus.estouro = 1'b0;
    wait_idle(100);
    repeat (5) begin
      @(negedge clk);
      chk("erro_sticky", bus.erro, 1);
    end
    start(2, t);
    chk("erro_cleared_on_start", bus.erro, 0);
    push(t, 2, 0, 1'b0);
    wait_idle(100);

    // Asynchronous reset in the 3rd hab cycle, then a full restart.
    start(8, t);
    push(t, 8, 0, 1'b0);
    wait_cyc(t + 4);
    chk("hab_before_reset", bus.hab, 1);
    #1;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_outputs", outs, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start(8, t);
    push(t, 8, 0, 1'b0);
    wait_idle(100);

    // Full-scale window.
    start((1 << JAN_W) - 1, t);
    push(t, (1 << JAN_W) - 1, 0, 1'b0);
    wait_idle(70000);

`ifdef JANELA_CONT_EN
    // Continuous mode: back-to-back sequences every 7 cycles.
    bus.continuo = 1'b1;
    start(2, t);
    push(t, 2, 0, 1'b1);
    push(t + 7, 2, 0, 1'b1);
    push(t + 14, 2, 0, 1'b0);
    wait_cyc(t + 15);
    bus.continuo = 1'b0;
    wait_idle(100);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  // Global time bound.
  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
